// File: rtl/key_entry_ctrl_pkg.sv
// Shared types and constants for the alarm-clock key entry controller.
package key_ctrl_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SHOW_ALARM,
    SET_ALARM_TIME,
    SET_CURRENT_TIME
  } state_t;

  localparam logic [3:0] NOKEY            = 4'hA;
  localparam logic [2:0] DIGITS_PER_ENTRY = 3'd4;
  localparam int         TIMER_W          = 4;

endpackage

// File: rtl/key_entry_timer.sv
// Inactivity timer for key entry: counts one_second ticks while enabled and
// flags the tick that completes the TIMEOUT_SEC-second window.
module key_entry_timer
  import key_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic timeout
);

  logic [TIMER_W-1:0] timer;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      timer <= '0;
    end else if (enable && tick && (timer != '1)) begin
      timer <= timer + 1'b1;
    end
  end

  always_comb begin
    timeout = enable && tick && (timer == TIMER_W'(TIMEOUT_SEC - 1));
  end

endmodule

// File: rtl/key_entry_ctrl.sv
// Key entry sequencer for the alarm clock: one shift per key press, digit
// counting, inactivity timeout and alarm/current-time commit.
// Build option: define KEY_DEBOUNCE_EN to require a key to be stable for two samples.
module key_entry_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       shift,
  output logic       show_new_time,
  output logic       show_a,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic [2:0] digit_count
);

  state_t state, next_state;
  logic   key_hit;
  logic   timeout;
  logic   full;

`ifdef KEY_DEBOUNCE_EN
  logic [3:0] prev_key;

  always_ff @(posedge clock) begin
    if (reset) prev_key <= NOKEY;
    else       prev_key <= key;
  end

  assign key_hit = (key != NOKEY) && (key == prev_key);
`else
  assign key_hit = (key != NOKEY);
`endif

  key_entry_timer #(.TIMEOUT_SEC(TIMEOUT_SEC)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == KEY_STORED),
    .enable  ((state == KEY_WAITED) || (state == KEY_ENTRY)),
    .tick    (one_second),
    .timeout (timeout)
  );

  assign full = (digit_count == DIGITS_PER_ENTRY);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= SHOW_TIME;
      digit_count <= '0;
    end else begin
      state <= next_state;
      if (state == SHOW_TIME)
        digit_count <= '0;
      else if ((state == KEY_STORED) && !full)
        digit_count <= digit_count + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      SHOW_TIME: begin
        if (alarm_button)  next_state = SHOW_ALARM;
        else if (key_hit)  next_state = KEY_STORED;
      end
      KEY_STORED:          next_state = KEY_WAITED;
      KEY_WAITED: begin
        if (timeout)           next_state = SHOW_TIME;
        else if (key == NOKEY) next_state = KEY_ENTRY;
      end
      KEY_ENTRY: begin
        if (alarm_button && full)     next_state = SET_ALARM_TIME;
        else if (time_button && full) next_state = SET_CURRENT_TIME;
        else if (key_hit)             next_state = KEY_STORED;
        else if (timeout)             next_state = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button) next_state = SHOW_TIME;
      end
      SET_ALARM_TIME:      next_state = SHOW_TIME;
      SET_CURRENT_TIME:    next_state = SHOW_TIME;
      default:             next_state = SHOW_TIME;
    endcase
  end

  always_comb begin
    shift         = (state == KEY_STORED);
    show_new_time = (state == KEY_WAITED) || (state == KEY_ENTRY);
    show_a        = (state == SHOW_ALARM);
    load_new_a    = (state == SET_ALARM_TIME);
    load_new_c    = (state == SET_CURRENT_TIME);
  end

endmodule

// File: doc/key_entry_ctrl.md
Name: key_entry_ctrl

Overview:
Controller FSM that sequences the alarm-clock key shift register. It detects each new keypad press and issues a single-cycle shift pulse to the key register. It tracks how many digits have been entered and applies an inactivity timeout. It commits the entered time as a new alarm time or current time on the corresponding button press, and drives the display-select signals.

Parameters:
TIMEOUT_SEC, 10, number of one_second pulses without a key press before key entry is abandoned (range 2..15)

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset, sampled on rising edge of clock
one_second  input  1  single-cycle pulse, once per second
key  input  4  keypad code: 0-9 = digit, 4'hA = NOKEY (no key pressed)
alarm_button  input  1  level; show alarm / commit alarm time
time_button  input  1  level; commit current time
shift  output  1  one-cycle pulse; key register shifts in key
show_new_time  output  1  display shows key-register contents
show_a  output  1  display shows stored alarm time
load_new_a  output  1  one-cycle pulse; alarm register loads key-register contents
load_new_c  output  1  one-cycle pulse; counter loads key-register contents
digit_count  output  3  digits entered this session, 0..4, saturating

Behaviour:
- Reset (synchronous, highest priority): state=SHOW_TIME, timer=0, digit_count=0, all outputs 0. Reset mid-entry discards the session and issues no load pulse.
- All outputs decode from registered state/counters only (Moore). There is no combinational input-to-output path.
- States and exits, listed in priority order within each state:
  - SHOW_TIME: all outputs 0; digit_count cleared.
    - alarm_button -> SHOW_ALARM
    - key!=NOKEY -> KEY_STORED
  - KEY_STORED: shift=1 for exactly one cycle; digit_count increments, saturating at 4.
    - Always -> KEY_WAITED
  - KEY_WAITED: show_new_time=1; waits for key release.
    - timeout -> SHOW_TIME
    - key==NOKEY -> KEY_ENTRY
  - KEY_ENTRY: show_new_time=1.
    - alarm_button and digit_count==4 -> SET_ALARM_TIME
    - time_button and digit_count==4 -> SET_CURRENT_TIME
    - key!=NOKEY -> KEY_STORED
    - timeout -> SHOW_TIME
    - Buttons pressed while digit_count<4 are ignored.
  - SHOW_ALARM: show_a=1.
    - Held while alarm_button=1; release -> SHOW_TIME.
  - SET_ALARM_TIME: load_new_a=1 for one cycle.
    - Always -> SHOW_TIME
  - SET_CURRENT_TIME: load_new_c=1 for one cycle.
    - Always -> SHOW_TIME
- Simultaneous alarm_button and time_button in KEY_ENTRY: alarm wins.
- Holding a key produces exactly one shift; a new shift requires passing through NOKEY.
- Timer:
  - Cleared while in KEY_STORED.
  - Increments on one_second while in KEY_WAITED or KEY_ENTRY.
  - timeout = one_second && timer==TIMEOUT_SEC-1, so the TIMEOUT_SEC-th pulse causes the exit on that edge.
  - Timer is 4 bits wide and never wraps (the state exits first).
- Latency: key press sampled at edge N -> shift high in cycle N+1. Commit button sampled at edge N -> load pulse in cycle N+1 -> SHOW_TIME at N+2.

Optional Feature:
KEY_DEBOUNCE_EN
- Defined: the transition to KEY_STORED requires key!=NOKEY and key equal to its previous-cycle registered value (stable for 2 consecutive samples). This adds 1 cycle of latency. The previous-key register resets to NOKEY.
- Undefined: single-sample detection as above; no extra register.

Decomposition:
- Package key_ctrl_pkg:
  - state enum (7 states)
  - NOKEY=4'hA
  - DIGITS_PER_ENTRY=4
  - TIMER_W=4
- Sub-module key_entry_timer: timeout counter with clear and increment enables, parameter TIMEOUT_SEC, output timeout.
- The FSM stays in key_entry_ctrl.

Test Plan:
- Reset asserted while in KEY_ENTRY with digit_count=3 -> next cycle state SHOW_TIME, digit_count=0, all outputs 0, no load pulse.
- Keys 1,2,3,4, each held 3 cycles then NOKEY, followed by time_button -> exactly 4 single-cycle shift pulses, digit_count=4, one load_new_c pulse, return to SHOW_TIME.
- Three digits then alarm_button -> no load_new_a; stays in KEY_ENTRY; a 4th digit then alarm_button -> one load_new_a pulse.
- Key 5 entered, then 10 one_second pulses with key=NOKEY -> exit to SHOW_TIME on the 10th pulse; show_new_time drops; no load pulse.
- Key held for 20 cycles -> exactly one shift pulse; alarm_button and time_button together with digit_count=4 -> load_new_a only.
- With KEY_DEBOUNCE_EN defined: key=7 for 1 cycle -> no shift; key=7 for 2 cycles -> shift one cycle later than in the non-debounce build.
